// File: rtl/mux_pkg.sv
// Shared encodings for the 2:1 stream mux and its demux counterpart.
// Keeping the select encoding here stops out_sel and demux s from drifting apart.
package mux_pkg;

    localparam logic SEL_CH0 = 1'b0;
    localparam logic SEL_CH1 = 1'b1;

    // Output register occupancy; the encoding matches out_valid bit-for-bit.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Channel index to one-hot request/grant position.
    function automatic logic [1:0] sel_to_onehot(input logic sel);
        return (sel == SEL_CH1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-requester round-robin arbiter; owns the last_sel history flop.
// last_sel only moves when a grant is actually consumed (advance).
module rr_arb_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx
);
    import mux_pkg::*;

    logic last_sel;

    always_comb begin
        grant     = 2'b00;
        grant_idx = SEL_CH0;
        case (req)
            2'b01: begin
                grant_idx = SEL_CH0;
                grant     = sel_to_onehot(SEL_CH0);
            end
            2'b10: begin
                grant_idx = SEL_CH1;
                grant     = sel_to_onehot(SEL_CH1);
            end
            2'b11: begin
                // Contention: the channel that did not win last time goes first.
                grant_idx = ~last_sel;
                grant     = sel_to_onehot(~last_sel);
            end
            default: begin
                grant     = 2'b00;
                grant_idx = SEL_CH0;
            end
        endcase
    end

    // Reset to CH1 so that channel 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sel <= SEL_CH1;
        end else if (advance && (grant != 2'b00)) begin
            last_sel <= grant_idx;
        end
    end

endmodule

// File: rtl/stream_mux_2x1.sv
// Registered 2:1 valid/ready stream merge with round-robin arbitration.
// Each output beat is tagged on out_sel with the channel it came from.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. Upstream holds valid/data until ready and never
// derives valid from ready; out_* change only on a handshake or on reset.
module stream_mux_2x1 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel,
    input  logic              out_ready
);
    import mux_pkg::*;

    out_state_e        state_q;
    out_state_e        state_d;
    logic              load;
    logic              any_grant;
    logic [1:0]        grant;
    logic              grant_idx;
    logic [DATA_W-1:0] data_q;
    logic              sel_q;

    // Register may take a new beat when empty or when its beat leaves this cycle.
    assign load      = (state_q == ST_EMPTY) || out_ready;
    assign any_grant = (grant != 2'b00);

    rr_arb_2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({in1_valid, in0_valid}),
        .advance   (load && !rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = any_grant ? ST_FULL : ST_EMPTY;
        end
    end

    // Readies are gated by rst because reset empties the register, which would
    // otherwise raise load while rst is still held.
    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        if (!rst && load) begin
            in0_ready = grant[0] && in0_valid;
            in1_ready = grant[1] && in1_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= SEL_CH0;
        end else if (load && any_grant) begin
            data_q <= (grant_idx == SEL_CH1) ? in1_data : in0_data;
            sel_q  <= grant_idx;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
